// File: rtl/por_pkg.sv
// Shared types and helpers for the POR resistor-string trip-point selector.
package por_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BREAK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam int TAP_BASE_DEF  = 28;
  localparam int TAP_TOTAL_DEF = 70;

  // Tap k counts down from the top of the string: k = 0 is the highest voltage.
  function automatic real vtap(input real avdd, input int k, input int n_taps,
                               input int base, input int total);
    return avdd * real'(n_taps - 1 - k + base) / real'(total);
  endfunction

endpackage

// File: rtl/rstring_tap_decode.sv
// Binary tap code to one-hot switch select, clamping out-of-range codes to the last tap.
module rstring_tap_decode #(
  parameter int N_TAPS = 8,
  parameter int CODE_W = $clog2(N_TAPS)
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [N_TAPS-1:0] onehot_o,
  output logic [CODE_W-1:0] tap_o,
  output logic              oor_o
);

  // Clamp and decode.
  always_comb begin
    oor_o            = ({{(32-CODE_W){1'b0}}, code_i} >= 32'(N_TAPS));
    tap_o            = oor_o ? CODE_W'(N_TAPS - 1) : code_i;
    onehot_o         = '0;
    onehot_o[tap_o]  = 1'b1;
  end

endmodule

// File: rtl/rstring_mux_seq.sv
// Clocked break-before-make tap selector for the POR comparator input, with
// programmable settle window and optional one-tap-per-step walking.
module rstring_mux_seq
  import por_pkg::*;
#(
  parameter int N_TAPS     = 8,
  parameter int TAP_BASE   = TAP_BASE_DEF,
  parameter int TAP_TOTAL  = TAP_TOTAL_DEF,
  parameter int SETTLE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  real                        avdd,
  input  logic                       ena,
  input  logic [$clog2(N_TAPS)-1:0]  trip_code,
  input  logic                       code_valid,
  input  logic                       step_mode,
  output real                        vin,
  output logic [N_TAPS-1:0]          tap_onehot,
  output logic [$clog2(N_TAPS)-1:0]  cur_tap,
  output logic                       busy,
  output logic                       settled,
  output logic                       code_err
);

  localparam int CODE_W = $clog2(N_TAPS);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   cur_q, cur_d;
  logic [CODE_W-1:0]   target_q, target_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_TAPS-1:0]   onehot_q, onehot_d;
  logic                settled_q, settled_d;
  logic                err_q, err_d;

  logic [CODE_W-1:0]   trip_tap_s;
  logic                trip_oor_s;
  logic [N_TAPS-1:0]   trip_onehot_s;
  logic [CODE_W-1:0]   next_tap_s;
  logic [CODE_W-1:0]   next_tap_chk_s;
  logic [N_TAPS-1:0]   next_onehot_s;
  logic                next_oor_s;
  logic                unused_s;

  rstring_tap_decode #(.N_TAPS(N_TAPS), .CODE_W(CODE_W)) u_trip_dec (
    .code_i   (trip_code),
    .onehot_o (trip_onehot_s),
    .tap_o    (trip_tap_s),
    .oor_o    (trip_oor_s)
  );

  rstring_tap_decode #(.N_TAPS(N_TAPS), .CODE_W(CODE_W)) u_next_dec (
    .code_i   (next_tap_s),
    .onehot_o (next_onehot_s),
    .tap_o    (next_tap_chk_s),
    .oor_o    (next_oor_s)
  );

  assign unused_s = ^{trip_onehot_s, next_oor_s};

  // Tap closed at the next BREAK: either the target itself or one step toward it.
  assign next_tap_s = !step_mode           ? target_q :
                      (target_q > cur_q)   ? cur_q + CODE_W'(1) :
                      (target_q < cur_q)   ? cur_q - CODE_W'(1) : cur_q;

  // Next-state logic; the target register captures every strobe, even while busy or disabled.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    onehot_d  = onehot_q;
    settled_d = settled_q;
    target_d  = code_valid ? trip_tap_s : target_q;
    err_d     = code_valid & trip_oor_s;
    if (!ena) begin
      state_d   = ST_IDLE;
      onehot_d  = '0;
      settled_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // An open string (after reset or re-enable) always re-runs the sequence.
          if ((onehot_q == '0) || (target_q != cur_q)) begin
            state_d   = ST_BREAK;
            onehot_d  = '0;
            settled_d = 1'b0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_BREAK: begin
          state_d  = ST_SETTLE;
          cur_d    = next_tap_chk_s;
          onehot_d = next_onehot_s;
          cnt_d    = 8'(SETTLE_CYC - 1);
        end
        ST_SETTLE: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (target_q != cur_q) begin
            state_d   = ST_BREAK;
            onehot_d  = '0;
            settled_d = 1'b0;
          end else begin
            state_d   = ST_IDLE;
            settled_d = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          onehot_d = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      target_q  <= '0;
      cnt_q     <= 8'd0;
      onehot_q  <= '0;
      settled_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      onehot_q  <= onehot_d;
      settled_q <= settled_d;
      err_q     <= err_d;
    end
  end

  assign tap_onehot = onehot_q;
  assign cur_tap    = cur_q;
  assign busy       = (state_q != ST_IDLE);
  assign settled    = settled_q;
  assign code_err   = err_q;
  assign vin        = (ena && (onehot_q != '0)) ?
                      vtap(avdd, int'(cur_q), N_TAPS, TAP_BASE, TAP_TOTAL) : 0.0;

endmodule

// File: tb/tb_rstring_mux_seq.sv
// Directed bench for rstring_mux_seq: jump table plus step, retarget, enable/reset and clamp sequences.
module tb_rstring_mux_seq;

  logic       clk = 1'b0;
  logic       rst;
  real        avdd;

  logic       ena8, cv8, step8;
  logic [2:0] trip8;
  real        vin8;
  logic [7:0] oh8;
  logic [2:0] cur8;
  logic       busy8, set8, err8;

  logic       ena6, cv6, step6;
  logic [2:0] trip6;
  real        vin6;
  logic [5:0] oh6;
  logic [2:0] cur6;
  logic       busy6, set6, err6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int  code;
    int  chg;
    int  oh;
    real v;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  rstring_mux_seq u8 (
    .clk(clk), .rst(rst), .avdd(avdd), .ena(ena8), .trip_code(trip8),
    .code_valid(cv8), .step_mode(step8), .vin(vin8), .tap_onehot(oh8),
    .cur_tap(cur8), .busy(busy8), .settled(set8), .code_err(err8)
  );

  rstring_mux_seq #(.N_TAPS(6)) u6 (
    .clk(clk), .rst(rst), .avdd(avdd), .ena(ena6), .trip_code(trip6),
    .code_valid(cv6), .step_mode(step6), .vin(vin6), .tap_onehot(oh6),
    .cur_tap(cur6), .busy(busy6), .settled(set6), .code_err(err6)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    checks++;
    if ((act - exp) > 1.0e-5 || (exp - act) > 1.0e-5) begin
      errors++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  task automatic pulse8(input int c);
    trip8 = 3'(c);
    cv8   = 1'b1;
    tick(1);
    cv8   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{code: 7, chg: 1, oh: 'h80, v: 1.32};
    vecs[1] = '{code: 3, chg: 1, oh: 'h08, v: 1.508571};
    vecs[2] = '{code: 5, chg: 1, oh: 'h20, v: 1.414286};
    vecs[3] = '{code: 5, chg: 0, oh: 'h20, v: 1.414286};
    vecs[4] = '{code: 6, chg: 1, oh: 'h40, v: 1.367143};
    vecs[5] = '{code: 0, chg: 1, oh: 'h01, v: 1.65};

    rst = 1'b1; avdd = 3.3;
    ena8 = 1'b0; cv8 = 1'b0; step8 = 1'b0; trip8 = 3'd0;
    ena6 = 1'b0; cv6 = 1'b0; step6 = 1'b0; trip6 = 3'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_onehot", int'(oh8), 0);
    chk("rst_cur", int'(cur8), 0);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_settled", int'(set8), 0);
    chk("rst_err", int'(err8), 0);
    chk_r("rst_vin", vin8, 0.0);

    // Power-up on tap 0.
    ena8 = 1'b1;
    tick(1);
    chk("pu_break_busy", int'(busy8), 1);
    chk("pu_break_oh", int'(oh8), 0);
    tick(1);
    chk("pu_oh", int'(oh8), 'h01);
    chk_r("pu_vin", vin8, 1.65);
    tick(3);
    chk("pu_settled_early", int'(set8), 0);
    tick(1);
    chk("pu_settled", int'(set8), 1);
    chk("pu_busy_done", int'(busy8), 0);

    // Jump table.
    for (int r = 0; r < 6; r++) begin
      pulse8(vecs[r].code);
      chk("jmp_err", int'(err8), 0);
      tick(1);
      chk("jmp_busy_t1", int'(busy8), vecs[r].chg);
      chk("jmp_settled_t1", int'(set8), 1 - vecs[r].chg);
      if (vecs[r].chg != 0) begin
        chk("jmp_break_oh", int'(oh8), 0);
        chk_r("jmp_break_vin", vin8, 0.0);
      end
      tick(1);
      chk("jmp_oh_t2", int'(oh8), vecs[r].oh);
      tick(4);
      chk("jmp_cur", int'(cur8), vecs[r].code);
      chk("jmp_oh", int'(oh8), vecs[r].oh);
      chk_r("jmp_vin", vin8, vecs[r].v);
      chk("jmp_settled", int'(set8), 1);
      chk("jmp_busy", int'(busy8), 0);
    end

    // Step walk 0 -> 3.
    step8 = 1'b1;
    pulse8(3);
    for (int k = 1; k <= 16; k++) begin
      int tap;
      tick(1);
      tap = (k == 16) ? 3 : ((k % 5) == 1) ? -1 : (k - 2) / 5 + 1;
      chk("step_oh", int'(oh8), (tap < 0) ? 0 : (1 << tap));
      chk("step_busy", int'(busy8), (k < 16) ? 1 : 0);
      if (k == 2)  chk_r("step_vin1", vin8, 1.602857);
      if (k == 7)  chk_r("step_vin2", vin8, 1.555714);
      if (k == 12) chk_r("step_vin3", vin8, 1.508571);
    end
    chk("step_settled", int'(set8), 1);

    // Retarget mid-SETTLE: 3 -> toward 7, then back to 2.
    pulse8(7);
    tick(7);
    chk("rt_cur5", int'(cur8), 5);
    tick(1);
    pulse8(2);
    tick(1);
    chk("rt_no_abort", int'(oh8), 'h20);
    tick(2);
    chk("rt_reverse", int'(cur8), 4);
    chk("rt_reverse_oh", int'(oh8), 'h10);
    tick(13);
    chk("rt_busy_late", int'(busy8), 1);
    tick(1);
    chk("rt_cur", int'(cur8), 2);
    chk("rt_oh", int'(oh8), 'h04);
    chk("rt_settled", int'(set8), 1);
    chk("rt_busy", int'(busy8), 0);
    chk_r("rt_vin", vin8, 1.555714);

    // Enable drop mid-SETTLE, retained target, then reset mid-BREAK.
    step8 = 1'b0;
    pulse8(6);
    tick(2);
    chk("en_settle_oh", int'(oh8), 'h40);
    ena8 = 1'b0;
    #1;
    chk_r("en_vin_now", vin8, 0.0);
    tick(1);
    chk("en_oh", int'(oh8), 0);
    chk("en_settled", int'(set8), 0);
    chk("en_busy", int'(busy8), 0);
    chk("en_cur_kept", int'(cur8), 6);
    pulse8(1);
    tick(1);
    chk("en_off_busy", int'(busy8), 0);
    chk("en_off_cur", int'(cur8), 6);
    ena8 = 1'b1;
    tick(1);
    chk("en_rise_busy", int'(busy8), 1);
    tick(1);
    chk("en_rise_cur", int'(cur8), 1);
    chk("en_rise_oh", int'(oh8), 'h02);
    tick(4);
    chk("en_rise_settled", int'(set8), 1);
    pulse8(4);
    tick(1);
    chk("rb_in_break", int'(busy8), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_oh", int'(oh8), 0);
    chk("ar_cur", int'(cur8), 0);
    chk("ar_busy", int'(busy8), 0);
    chk("ar_settled", int'(set8), 0);
    chk("ar_err", int'(err8), 0);
    chk_r("ar_vin", vin8, 0.0);
    tick(1);
    rst = 1'b0;

    // Six-tap instance: out-of-range code clamps to tap 5.
    ena6  = 1'b1;
    trip6 = 3'd7;
    cv6   = 1'b1;
    tick(1);
    cv6   = 1'b0;
    chk("c6_err", int'(err6), 1);
    tick(1);
    chk("c6_err_clr", int'(err6), 0);
    chk("c6_oh", int'(oh6), 'h20);
    tick(4);
    chk("c6_cur", int'(cur6), 5);
    chk("c6_settled", int'(set6), 1);
    chk_r("c6_vin", vin6, 1.32);
    trip6 = 3'd5;
    cv6   = 1'b1;
    tick(1);
    cv6   = 1'b0;
    chk("c6_inrange_err", int'(err6), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
